// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl - pipeline control unit for the five-stage Y86-64 core.
//
// Produces the per-cycle stall/bubble controls for the F, D, E, M and W
// pipeline registers from the load-use, ret, mispredict and exception hazard
// terms, runs the RUN/DRAIN/HALTED machine that stops the core on an
// exception, and keeps saturating performance counters for debug.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   D_icode                 icode in the D register
//   d_srcA, d_srcB          decode source registers (4'hF = none)
//   E_icode, E_dstM         icode / load destination in the E register
//   e_Cnd                   execute-stage branch condition
//   M_icode                 icode in the M register
//   m_stat, W_stat          memory-stage / W register status
//   F_stall, D_stall        hold F / D register
//   D_bubble, E_bubble,
//   M_bubble                load a NOP into D / E / M
//   W_stall                 hold W register
//   set_cc                  condition-code update enable
//   halted, final_stat      core stopped, and the status that stopped it
//   cyc_cnt, lu_cnt,
//   mp_cnt, ret_cnt         saturating performance counters
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [3:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] R_NONE  = 4'hF;
    localparam logic [3:0] S_AOK   = 4'b1000;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t state, next_state;

    // Hazard terms. The load-use check is qualified on E_icode because a
    // bubbled E register carries dstM=0, which would otherwise match %rax.
    logic lu, rt, mp, mx, wx;

    assign lu = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                (E_dstM != R_NONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mp = (E_icode == I_JXX) && !e_Cnd;
    assign mx = (m_stat != S_AOK);
    assign wx = (W_stat != S_AOK);

    // Next-state logic. A W-stage exception halts immediately, even over a
    // concurrent M-stage exception; an M-stage exception alone drains first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        next_state = state;
        unique case (state)
            ST_RUN: begin
                if (wx)      next_state = ST_HALTED;
                else if (mx) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wx) next_state = ST_HALTED;
            end
            default: next_state = ST_HALTED;
        endcase
    end

    // Pipeline controls. Reset is folded in combinationally so the unreset
    // pipeline registers are flushed with NOPs for as long as rst_n is low.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (!rst_n) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (state == ST_HALTED) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
        end else begin
            F_stall  = lu | rt;
            D_stall  = lu;
            // A load-use stall holds D, so the ret bubble waits a cycle.
            D_bubble = mp | (rt & ~lu);
            E_bubble = mp | lu;
            M_bubble = mx | wx;
            W_stall  = wx;
            set_cc   = (E_icode == I_OPQ) & ~mx & ~wx;
        end
    end

    // State, halt flag and final status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            halted     <= 1'b0;
            final_stat <= S_AOK;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state <= next_state;
            if ((state != ST_HALTED) && (next_state == ST_HALTED)) begin
                halted     <= 1'b1;
                final_stat <= W_stat;
            end
        end
    end

    // Saturating performance counters, frozen once the core has halted.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic cnt_en;
    assign cnt_en = (state != ST_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            lu_cnt  <= '0;
            mp_cnt  <= '0;
            ret_cnt <= '0;
        end else if (cnt_en) begin
            cyc_cnt <= sat_inc(cyc_cnt);
            if (lu)       lu_cnt  <= sat_inc(lu_cnt);
            if (mp)       mp_cnt  <= sat_inc(mp_cnt);
            if (rt && !lu) ret_cnt <= sat_inc(ret_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl - self-checking bench for pipe_ctrl.
//
// Two instances share all inputs: a 32-bit-counter one and a 4-bit-counter
// one for saturation. A behavioural model (hazard rules, a stopped flag and
// plain integer counts) predicts every output; a negedge process compares
// both instances against it each cycle. Directed sequences with literal
// expectations pin the model, then randomized episodes follow.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] HLT = 4'b0100;
    localparam logic [3:0] ADR = 4'b0010;
    localparam logic [3:0] INS = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
    logic        e_Cnd;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [3:0]  final_stat;
    logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    logic        F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc4, halted4;
    logic [3:0]  final_stat4;
    logic [3:0]  cyc4, lu4, mp4, ret4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .halted(halted), .final_stat(final_stat), .cyc_cnt(cyc_cnt),
        .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall4), .D_stall(D_stall4),
        .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_stall(W_stall4),
        .set_cc(set_cc4), .halted(halted4), .final_stat(final_stat4), .cyc_cnt(cyc4),
        .lu_cnt(lu4), .mp_cnt(mp4), .ret_cnt(ret4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit h_lu();
        return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction
    function automatic bit h_rt();
        return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    endfunction
    function automatic bit h_mp();
        return E_icode == 4'h7 && !e_Cnd;
    endfunction
    function automatic int unsigned sat15(input int unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    bit          m_stopped;
    logic [3:0]  m_final;
    int unsigned m_cyc, m_lu, m_mp, m_ret;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stopped = 0; m_final = AOK;
            m_cyc = 0; m_lu = 0; m_mp = 0; m_ret = 0;
        end else if (!m_stopped) begin
            m_cyc += 1;
            if (h_lu()) m_lu += 1;
            if (h_mp()) m_mp += 1;
            if (h_rt() && !h_lu()) m_ret += 1;
            if (W_stat != AOK) begin
                m_stopped = 1;
                m_final   = W_stat;
            end
        end
    end

    // Expected controls packed {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}.
    function automatic logic [6:0] exp_ctl();
        bit l, r, m, mx, wx;
        if (!rst_n)   return 7'b1011100;
        if (m_stopped) return 7'b1101110;
        l = h_lu(); r = h_rt(); m = h_mp();
        mx = (m_stat != AOK); wx = (W_stat != AOK);
        return {l | r, l, m | (r & !l), m | l, mx | wx, wx, (E_icode == 4'h6) & !mx & !wx};
    endfunction

    always @(negedge clk) begin
        check("ctl",      {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, exp_ctl());
        check("ctl4",     {F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc4}, exp_ctl());
        check("halted",   halted, m_stopped);
        check("final",    final_stat, m_final);
        check("halted4",  {halted4, final_stat4}, {m_stopped, m_final});
        check("cyc_cnt",  cyc_cnt, m_cyc);
        check("lu_cnt",   lu_cnt,  m_lu);
        check("mp_cnt",   mp_cnt,  m_mp);
        check("ret_cnt",  ret_cnt, m_ret);
        check("cyc4",     cyc4, sat15(m_cyc));
        check("lu4",      lu4,  sat15(m_lu));
        check("mp4",      mp4,  sat15(m_mp));
        check("ret4",     ret4, sat15(m_ret));
    end

    // ---------------- stimulus helpers ----------------
    task automatic nops();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b0;
        m_stat = AOK; W_stat = AOK;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rand_inputs();
        logic [3:0] e_pick [6] = '{4'h5, 4'hB, 4'h7, 4'h6, 4'h9, 4'h1};
        logic [3:0] exc [3] = '{HLT, ADR, INS};
        D_icode = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 11));
        E_icode = ($urandom_range(0, 1) == 0) ? e_pick[$urandom_range(0, 5)] : 4'($urandom_range(0, 11));
        M_icode = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'($urandom_range(0, 11));
        E_dstM  = 4'($urandom_range(0, 15));
        d_srcA  = ($urandom_range(0, 2) == 0) ? E_dstM : 4'($urandom_range(0, 15));
        d_srcB  = ($urandom_range(0, 3) == 0) ? E_dstM : 4'($urandom_range(0, 15));
        e_Cnd   = 1'($urandom_range(0, 1));
        m_stat  = ($urandom_range(0, 39) == 0) ? exc[$urandom_range(0, 2)] : AOK;
        W_stat  = ($urandom_range(0, 59) == 0) ? exc[$urandom_range(0, 2)] : AOK;
    endtask

    initial begin
        nops();
        #1;
        check("rst F_stall", F_stall, 1'b1);
        check("rst bubbles", {D_bubble, E_bubble, M_bubble}, 3'b111);
        check("rst D/W/cc",  {D_stall, W_stall, set_cc}, 3'b000);
        #11 rst_n = 1'b1;

        // Idle pipeline of NOPs.
        step(5);
        check("idle ctl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, 6'b0);
        check("idle cyc", cyc_cnt, 32'd5);
        check("idle halt", {halted, final_stat}, {1'b0, 4'b1000});

        // Load-use hazard, then same with dstM=none.
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
        check("lu ctl", {F_stall, D_stall, E_bubble, D_bubble}, 4'b1110);
        step(1);
        check("lu cnt", lu_cnt, 32'd1);
        E_dstM = 4'hF; #1;
        check("lu none", {F_stall, D_stall, E_bubble}, 3'b000);
        step(1);

        // Mispredict, then taken jump.
        nops(); E_icode = 4'h7; e_Cnd = 1'b0; #1;
        check("mp ctl", {D_bubble, E_bubble, F_stall}, 3'b110);
        step(1);
        check("mp cnt", mp_cnt, 32'd1);
        e_Cnd = 1'b1; #1;
        check("taken ctl", {F_stall, D_stall, D_bubble, E_bubble}, 4'b0);
        step(1);

        // ret walking D -> E -> M.
        nops(); D_icode = 4'h9; #1;
        check("ret1", {F_stall, D_bubble}, 2'b11);
        step(1); D_icode = 4'h1; E_icode = 4'h9; #1;
        check("ret2", {F_stall, D_bubble}, 2'b11);
        step(1); E_icode = 4'h1; M_icode = 4'h9; #1;
        check("ret3", {F_stall, D_bubble}, 2'b11);
        step(1); nops();
        check("ret cnt", ret_cnt, 32'd3);

        // ret with load-use in its first cycle.
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
        check("ret+lu", {D_stall, D_bubble}, 2'b10);
        step(1); nops(); E_icode = 4'h9;
        step(1); E_icode = 4'h1; M_icode = 4'h9;
        step(1); nops();
        check("ret cnt2", ret_cnt, 32'd5);

        // Exception: ADR in M then W.
        m_stat = ADR; #1;
        check("mx bubble", M_bubble, 1'b1);
        step(1); m_stat = AOK; W_stat = ADR; #1;
        check("wx bubble", {M_bubble, halted}, 2'b10);
        step(1); W_stat = AOK; E_icode = 4'h6;
        check("halt", {halted, final_stat}, {1'b1, 4'b0010});
        check("halt cc", set_cc, 1'b0);
        step(3);
        check("frozen cyc", cyc_cnt, 32'd17);
        check("sat cyc4", cyc4, 4'd15);

        // Randomized episodes, each opened by an asynchronous mid-cycle reset.
        for (int ep = 0; ep < 8; ep++) begin
            #1 rst_n = 1'b0;
            #1;
            check("async cnt", {cyc_cnt, lu_cnt, mp_cnt, ret_cnt}, 64'd0);
            check("async ctl", {F_stall, halted}, 2'b10);
            #10 rst_n = 1'b1;
            step(1);
            for (int c = 0; c < 120; c++) begin
                rand_inputs();
                step(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
